// File: rtl/data_sram_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | data_sram_responder: word-addressed data SRAM with byte-lane writes,     |
// | one-cycle response pulse and optional wait states (macro DSRAM_WAIT_EN). |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module data_sram_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        resp_valid,
  output logic        stall_req,
  output logic        addr_err
);

  localparam int c_DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [31:0]       r_mem [0:c_DEPTH-1];
  logic [31:0]       r_rdata;
  logic              r_addr_err;
  logic              w_accept;
  logic              w_start_wait;
  logic              w_exec;
  logic              w_bad_align;
  logic [ADDR_W-1:0] w_idx;
  logic [3:0]        w_wen;
  logic [31:0]       w_wdata;
  logic              w_unused;

  // Reset is folded in so stall_req reads 0 the moment rst rises.
  assign w_accept    = data_sram_en && (r_state != S_WAIT) && !rst;
  assign w_bad_align = (data_sram_addr[1:0] != 2'b00) &&
                       ((data_sram_wen == 4'hF) || (data_sram_wen == 4'h0));
  assign w_unused    = ^{data_sram_addr[31:ADDR_W+2], WAIT_CYCLES[0]};

`ifdef DSRAM_WAIT_EN
  localparam bit         c_HAS_WAIT = (WAIT_CYCLES != 0);
  localparam logic [3:0] c_CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_idx;
  logic [3:0]        r_wen;
  logic [31:0]       r_wdata;
  logic              w_exec_latched;

  assign w_exec_latched = (r_state == S_WAIT) && (r_cnt == 4'd0);
  assign w_start_wait   = w_accept && c_HAS_WAIT;
  assign w_exec         = w_exec_latched || (w_accept && !c_HAS_WAIT);
  assign w_idx          = w_exec_latched ? r_idx   : data_sram_addr[ADDR_W+1:2];
  assign w_wen          = w_exec_latched ? r_wen   : data_sram_wen;
  assign w_wdata        = w_exec_latched ? r_wdata : data_sram_wdata;
  assign stall_req      = (r_state == S_WAIT) || w_start_wait;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= 4'd0;
      r_idx   <= '0;
      r_wen   <= 4'd0;
      r_wdata <= 32'd0;
    end else if (w_start_wait) begin
      r_cnt   <= c_CNT_INIT;
      r_idx   <= data_sram_addr[ADDR_W+1:2];
      r_wen   <= data_sram_wen;
      r_wdata <= data_sram_wdata;
    end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end
`else
  assign w_start_wait = 1'b0;
  assign w_exec       = w_accept;
  assign w_idx        = data_sram_addr[ADDR_W+1:2];
  assign w_wen        = data_sram_wen;
  assign w_wdata      = data_sram_wdata;
  assign stall_req    = 1'b0;
`endif

  always_comb begin
    w_state_nxt = S_IDLE;
    if (w_exec)
      w_state_nxt = S_RESP;
    else if (w_start_wait || (r_state == S_WAIT))
      w_state_nxt = S_WAIT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_rdata    <= 32'd0;
      r_addr_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept)
        r_addr_err <= w_bad_align;
      if (w_exec && (w_wen == 4'h0))
        r_rdata <= r_mem[w_idx];
    end
  end

  // Array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_exec) begin
      for (int i = 0; i < 4; i++) begin
        if (w_wen[i])
          r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

  assign data_sram_rdata = r_rdata;
  assign resp_valid      = (r_state == S_RESP);
  assign addr_err        = r_addr_err;

endmodule
`default_nettype wire

// File: tb/tb_data_sram_responder.sv
`default_nettype none
// Scoreboard bench for data_sram_responder; expected responses are queued at
// issue time and popped by a monitor whenever resp_valid is seen.
module tb_data_sram_responder;

`ifdef DSRAM_WAIT_EN
  localparam int TB_W = 2;
`else
  localparam int TB_W = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        resp_valid;
  logic        stall_req;
  logic        addr_err;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          cyc;
    string       nm;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  logic [31:0] last_rd;

  data_sram_responder dut (
    .clk             (clk),
    .rst             (rst),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .resp_valid      (resp_valid),
    .stall_req       (stall_req),
    .addr_err        (addr_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && resp_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.nm, "_rdata"}, data_sram_rdata, e.rd);
        chk({e.nm, "_addr_err"}, {31'd0, addr_err}, {31'd0, e.err});
        chk({e.nm, "_cycle"}, 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic drive(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata);
    data_sram_en    = 1'b1;
    data_sram_wen   = wen;
    data_sram_addr  = addr;
    data_sram_wdata = wdata;
  endtask

  task automatic push(input string nm, input logic [3:0] wen, input logic [31:0] rd, input logic err);
    exp_t e;
    if (wen == 4'h0) last_rd = rd;
    e.rd  = last_rd;
    e.err = err;
    e.cyc = cyc + 1 + TB_W;
    e.nm  = nm;
    sb.push_back(e);
  endtask

  // One request, then idle until the responder stops stalling.
  task automatic do_req(input string nm, input logic [3:0] wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rd, input logic err);
    int k;
    @(posedge clk); #1;
    drive(wen, addr, wdata);
    push(nm, wen, rd, err);
    @(posedge clk); #1;
    data_sram_en = 1'b0;
    k = 0;
    while (stall_req && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 20) chk({nm, "_stall_timeout"}, 32'd1, 32'd0);
  endtask

  initial begin
    int k;
    rst = 1'b1;
    data_sram_en = 1'b0; data_sram_wen = 4'h0; data_sram_addr = 32'd0; data_sram_wdata = 32'd0;
    last_rd = 32'd0;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_rdata", data_sram_rdata, 32'd0);
    chk("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("reset_stall", {31'd0, stall_req}, 32'd0);
    chk("reset_addr_err", {31'd0, addr_err}, 32'd0);
    @(posedge clk); #3;
    rst = 1'b0;

    do_req("wr_full",   4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0);
    do_req("rd_full",   4'h0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0);
    do_req("wr_pre",    4'hF, 32'h0000_0010, 32'h1122_3344, 32'h0, 1'b0);
    do_req("wr_lane",   4'h5, 32'h0000_0010, 32'hAABB_CCDD, 32'h0, 1'b0);
    do_req("rd_lane",   4'h0, 32'h0000_0010, 32'h0,         32'h11BB_33DD, 1'b0);
    do_req("wr_alias",  4'hF, 32'h0000_1010, 32'hCAFE_F00D, 32'h0, 1'b0);
    do_req("rd_alias",  4'h0, 32'h0000_0010, 32'h0,         32'hCAFE_F00D, 1'b0);
    do_req("rd_misal",  4'h0, 32'h0000_0012, 32'h0,         32'hCAFE_F00D, 1'b1);
    do_req("wr_half",   4'h3, 32'h0000_0011, 32'h0000_1234, 32'h0, 1'b0);
    do_req("rd_half",   4'h0, 32'h0000_0010, 32'h0,         32'hCAFE_1234, 1'b0);
    do_req("wr_misalf", 4'hF, 32'h0000_0011, 32'hFFFF_FFFF, 32'h0, 1'b1);
    do_req("rd_after",  4'h0, 32'h0000_0010, 32'h0,         32'hFFFF_FFFF, 1'b0);

`ifdef DSRAM_WAIT_EN
    // Read in cycle c: stall c..c+2, response in c+3 only; a request in c+1 is dropped.
    @(posedge clk); #1;
    drive(4'h0, 32'h0000_0010, 32'h0);
    push("rd_wait", 4'h0, 32'hFFFF_FFFF, 1'b0);
    #1; chk("wait_stall_c0", {31'd0, stall_req}, 32'd1);
    @(posedge clk); #1;
    drive(4'hF, 32'h0000_0010, 32'h0000_0000);
    chk("wait_stall_c1", {31'd0, stall_req}, 32'd1);
    chk("wait_resp_c1", {31'd0, resp_valid}, 32'd0);
    @(posedge clk); #1;
    data_sram_en = 1'b0;
    chk("wait_stall_c2", {31'd0, stall_req}, 32'd1);
    chk("wait_resp_c2", {31'd0, resp_valid}, 32'd0);
    @(posedge clk); #1;
    chk("wait_stall_c3", {31'd0, stall_req}, 32'd0);
    chk("wait_resp_c3", {31'd0, resp_valid}, 32'd1);
    @(posedge clk); #1;
    chk("wait_resp_c4", {31'd0, resp_valid}, 32'd0);
    do_req("rd_ignored", 4'h0, 32'h0000_0010, 32'h0, 32'hFFFF_FFFF, 1'b0);
`else
    // Write in cycle 0, read same word in cycle 1.
    @(posedge clk); #1;
    drive(4'hF, 32'h0000_0020, 32'h5A5A_5A5A);
    chk("nowait_stall", {31'd0, stall_req}, 32'd0);
    push("b2b_wr", 4'hF, 32'h0, 1'b0);
    @(posedge clk); #1;
    drive(4'h0, 32'h0000_0020, 32'h0);
    push("b2b_rd", 4'h0, 32'h5A5A_5A5A, 1'b0);
    @(posedge clk); #1;
    data_sram_en = 1'b0;
`endif

    // Reset in the middle of a write access.
    do_req("wr_pre30", 4'hF, 32'h0000_0030, 32'h0BAD_F00D, 32'h0, 1'b0);
    @(posedge clk); #1;
    drive(4'hF, 32'h0000_0030, 32'h1234_5678);
    @(posedge clk); #1;
    data_sram_en = 1'b0;
`ifdef DSRAM_WAIT_EN
    chk("rst_pre_stall", {31'd0, stall_req}, 32'd1);
`endif
    #2 rst = 1'b1;
    #1;
    chk("midrst_rdata", data_sram_rdata, 32'd0);
    chk("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("midrst_stall", {31'd0, stall_req}, 32'd0);
    chk("midrst_addr_err", {31'd0, addr_err}, 32'd0);
    last_rd = 32'd0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
`ifdef DSRAM_WAIT_EN
    do_req("rd_rst30", 4'h0, 32'h0000_0030, 32'h0, 32'h0BAD_F00D, 1'b0);
`else
    do_req("rd_rst30", 4'h0, 32'h0000_0030, 32'h0, 32'h1234_5678, 1'b0);
`endif

    k = 0;
    while (sb.size() != 0 && k < 20) begin
      @(posedge clk);
      k++;
    end
    @(posedge clk); #1;
    chk("sb_drain", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
